// File: rtl/pkg_lobinho.sv
// Shared definitions for the werewolf night controller: class encoding,
// FSM state encoding (doubles as the 7-segment debug code) and default sizing.
package pkg_lobinho;

    localparam int unsigned N_JOGADORES_PADRAO = 5;

    localparam logic [1:0] CLASSE_ALDEAO  = 2'd0;
    localparam logic [1:0] CLASSE_LOBO    = 2'd1;
    localparam logic [1:0] CLASSE_MEDICO  = 2'd2;
    localparam logic [1:0] CLASSE_VIDENTE = 2'd3;

    typedef enum logic [3:0] {
        StOcioso  = 4'd0,
        StAvalia  = 4'd1,
        StMostra  = 4'd2,
        StAcao    = 4'd3,
        StProximo = 4'd4,
        StResolve = 4'd5,
        StFim     = 4'd6
    } estado_t;

endpackage

// File: rtl/valida_alvo.sv
// Target legality check shared by wolf, doctor and seer: in range, alive and,
// unless permite_proprio is set, not the acting player.
module valida_alvo #(
    parameter int unsigned N_JOGADORES = 5,
    parameter int unsigned ID_W        = 3
) (
    input  logic [ID_W-1:0]        escolha,
    input  logic [ID_W-1:0]        jogador,
    input  logic [N_JOGADORES-1:0] vivos,
    input  logic                   permite_proprio,
    output logic                   valido
);

    logic vivo;

    always_comb begin
        // Out-of-range indices match no entry and so read as dead.
        vivo = 1'b0;
        for (int unsigned i = 0; i < N_JOGADORES; i++) begin
            if (escolha == ID_W'(i)) begin
                vivo = vivos[i];
            end
        end
        valido = vivo && (permite_proprio || (escolha != jogador));
    end

endmodule

// File: rtl/controle_noite.sv
// Night-round sequencer: walks the players, gates class display and actions,
// latches wolf/doctor targets and resolves the death. VIDENTE_EN adds the seer.
module controle_noite
    import pkg_lobinho::*;
#(
    parameter int unsigned N_JOGADORES = N_JOGADORES_PADRAO,
    parameter int unsigned ID_W        = 3
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     iniciar,
    input  logic                     passa,
    input  logic [ID_W-1:0]          escolha,
    input  logic                     escolha_valida,
    input  logic [2*N_JOGADORES-1:0] classes,
    input  logic [N_JOGADORES-1:0]   vivos_in,
    output logic [ID_W-1:0]          jogador_atual,
    output logic                     mostra_classe,
    output logic                     limpa_escolha,
    output logic [ID_W-1:0]          atacado,
    output logic [ID_W-1:0]          protegido,
    output logic [ID_W-1:0]          morto,
    output logic                     morto_valido,
    output logic [N_JOGADORES-1:0]   vivos_out,
    output logic                     fim_noite,
    output logic                     ocupado,
`ifdef VIDENTE_EN
    output logic [1:0]               revelacao,
    output logic                     revelacao_valida,
`endif
    output logic [3:0]               db_estado
);

    estado_t                estado_q, estado_d;
    logic [ID_W-1:0]        jogador_q, jogador_d;
    logic [N_JOGADORES-1:0] mascara_q, mascara_d;
    logic [ID_W-1:0]        atacado_q, atacado_d;
    logic                   atq_v_q, atq_v_d;
    logic [ID_W-1:0]        protegido_q, protegido_d;
    logic                   prot_v_q, prot_v_d;
    logic [ID_W-1:0]        morto_q, morto_d;
    logic                   morto_valido_q, morto_valido_d;
    logic [N_JOGADORES-1:0] vivos_out_q, vivos_out_d;

    logic [1:0]             classe_atual;
    logic                   vivo_atual;
    logic [N_JOGADORES-1:0] atacado_onehot;
    logic                   alvo_ok;

`ifdef VIDENTE_EN
    logic [1:0] revelacao_q, revelacao_d;
    logic       rev_v_q, rev_v_d;
    logic [1:0] classe_escolha;

    always_comb begin
        classe_escolha = CLASSE_ALDEAO;
        for (int unsigned i = 0; i < N_JOGADORES; i++) begin
            if (escolha == ID_W'(i)) begin
                classe_escolha = classes[2*i +: 2];
            end
        end
    end
`endif

    always_comb begin
        classe_atual   = CLASSE_ALDEAO;
        vivo_atual     = 1'b0;
        atacado_onehot = '0;
        for (int unsigned i = 0; i < N_JOGADORES; i++) begin
            if (jogador_q == ID_W'(i)) begin
                classe_atual = classes[2*i +: 2];
                vivo_atual   = mascara_q[i];
            end
            atacado_onehot[i] = (atacado_q == ID_W'(i));
        end
    end

    valida_alvo #(
        .N_JOGADORES (N_JOGADORES),
        .ID_W        (ID_W)
    ) u_valida_alvo (
        .escolha         (escolha),
        .jogador         (jogador_q),
        .vivos           (mascara_q),
        .permite_proprio (classe_atual == CLASSE_MEDICO),
        .valido          (alvo_ok)
    );

    always_comb begin
        estado_d       = estado_q;
        jogador_d      = jogador_q;
        mascara_d      = mascara_q;
        atacado_d      = atacado_q;
        atq_v_d        = atq_v_q;
        protegido_d    = protegido_q;
        prot_v_d       = prot_v_q;
        morto_d        = morto_q;
        morto_valido_d = morto_valido_q;
        vivos_out_d    = vivos_out_q;
`ifdef VIDENTE_EN
        revelacao_d    = revelacao_q;
        rev_v_d        = rev_v_q;
`endif
        unique case (estado_q)
            StOcioso: begin
                if (iniciar) begin
                    mascara_d      = vivos_in;
                    atq_v_d        = 1'b0;
                    prot_v_d       = 1'b0;
                    morto_valido_d = 1'b0;
                    jogador_d      = '0;
                    estado_d       = StAvalia;
                end
            end
            StAvalia:  estado_d = vivo_atual ? StMostra : StProximo;
            StMostra: begin
                if (passa) estado_d = StAcao;
            end
            StAcao: begin
                unique case (classe_atual)
                    CLASSE_LOBO: begin
                        // Only the first wolf to act picks the victim.
                        if (escolha_valida && alvo_ok) begin
                            if (!atq_v_q) begin
                                atacado_d = escolha;
                                atq_v_d   = 1'b1;
                            end
                            estado_d = StProximo;
                        end
                    end
                    CLASSE_MEDICO: begin
                        if (escolha_valida && alvo_ok) begin
                            protegido_d = escolha;
                            prot_v_d    = 1'b1;
                            estado_d    = StProximo;
                        end
                    end
`ifdef VIDENTE_EN
                    CLASSE_VIDENTE: begin
                        if (rev_v_q) begin
                            if (passa) begin
                                revelacao_d = '0;
                                rev_v_d     = 1'b0;
                                estado_d    = StProximo;
                            end
                        end else if (escolha_valida && alvo_ok) begin
                            revelacao_d = classe_escolha;
                            rev_v_d     = 1'b1;
                        end
                    end
                    CLASSE_ALDEAO: begin
                        if (passa) estado_d = StProximo;
                    end
`else
                    CLASSE_ALDEAO, CLASSE_VIDENTE: begin
                        if (passa) estado_d = StProximo;
                    end
`endif
                endcase
            end
            StProximo: begin
                if (jogador_q == ID_W'(N_JOGADORES - 1)) begin
                    estado_d = StResolve;
                end else begin
                    jogador_d = jogador_q + ID_W'(1);
                    estado_d  = StAvalia;
                end
            end
            StResolve: begin
                if (atq_v_q && !(prot_v_q && (protegido_q == atacado_q))) begin
                    morto_d        = atacado_q;
                    morto_valido_d = 1'b1;
                    vivos_out_d    = mascara_q & ~atacado_onehot;
                end else begin
                    morto_valido_d = 1'b0;
                    vivos_out_d    = mascara_q;
                end
                estado_d = StFim;
            end
            StFim:     estado_d = StOcioso;
            default:   estado_d = StOcioso;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            estado_q       <= StOcioso;
            jogador_q      <= '0;
            mascara_q      <= '1;
            atacado_q      <= '0;
            atq_v_q        <= 1'b0;
            protegido_q    <= '0;
            prot_v_q       <= 1'b0;
            morto_q        <= '0;
            morto_valido_q <= 1'b0;
            vivos_out_q    <= '1;
`ifdef VIDENTE_EN
            revelacao_q    <= '0;
            rev_v_q        <= 1'b0;
`endif
        end else begin
            estado_q       <= estado_d;
            jogador_q      <= jogador_d;
            mascara_q      <= mascara_d;
            atacado_q      <= atacado_d;
            atq_v_q        <= atq_v_d;
            protegido_q    <= protegido_d;
            prot_v_q       <= prot_v_d;
            morto_q        <= morto_d;
            morto_valido_q <= morto_valido_d;
            vivos_out_q    <= vivos_out_d;
`ifdef VIDENTE_EN
            revelacao_q    <= revelacao_d;
            rev_v_q        <= rev_v_d;
`endif
        end
    end

    assign jogador_atual = jogador_q;
    assign mostra_classe = (estado_q == StMostra);
    assign limpa_escolha = (estado_q == StAvalia) && vivo_atual;
    assign atacado       = atacado_q;
    assign protegido     = protegido_q;
    assign morto         = morto_q;
    assign morto_valido  = morto_valido_q;
    assign vivos_out     = vivos_out_q;
    assign fim_noite     = (estado_q == StFim);
    assign ocupado       = (estado_q != StOcioso);
    assign db_estado     = estado_q;
`ifdef VIDENTE_EN
    assign revelacao        = revelacao_q;
    assign revelacao_valida = rev_v_q;
`endif

endmodule

// File: doc/controle_noite.md
Name: controle_noite

Overview:
- Sequences one night round of the werewolf game.
- Walks every player in turn and gates the class display and the action window per player.
- Latches the wolf's attack target and the doctor's protection target, then resolves the night outcome.
- Sits between the main control unit (which pulses `iniciar` once per night) and the button-converter / player-register datapath.

Parameters:
- N_JOGADORES, 5, number of players; legal range 2..8.
- ID_W, 3, width of a player index; must satisfy 2^ID_W >= N_JOGADORES.

Ports:
- clock  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-low reset, sampled on the rising edge of clock.
- iniciar  in  1  one-cycle pulse; starts a night round; ignored unless in OCIOSO.
- passa  in  1  one-cycle pulse (already edge-detected); advances the display/turn.
- escolha  in  ID_W  index of the player chosen with the buttons.
- escolha_valida  in  1  escolha is stable and meaningful this cycle.
- classes  in  2*N_JOGADORES  flat class vector; player i = classes[2i+1:2i]. Encoding: 0 aldeao, 1 lobo, 2 medico, 3 vidente.
- vivos_in  in  N_JOGADORES  alive mask at night start.
- jogador_atual  out  ID_W  player whose turn it is.
- mostra_classe  out  1  show the class of jogador_atual.
- limpa_escolha  out  1  one-cycle pulse clearing the button-converter register.
- atacado  out  ID_W  latched wolf target.
- protegido  out  ID_W  latched doctor target.
- morto  out  ID_W  player killed this night.
- morto_valido  out  1  morto holds a real death.
- vivos_out  out  N_JOGADORES  alive mask after resolution.
- fim_noite  out  1  one-cycle pulse when the round completes.
- ocupado  out  1  high in every state except OCIOSO.
- db_estado  out  4  state encoding for the 7-segment display.

Behaviour:
- Reset (reset==0 on an edge):
  - state = OCIOSO.
  - jogador_atual = 0; atacado = protegido = morto = 0.
  - Flags atq_v / prot_v cleared; morto_valido = 0.
  - vivos_out = all ones.
  - All pulse outputs low.
  - A reset mid-round aborts the round with no resolution.
- States:
  - OCIOSO 0: wait for iniciar. On iniciar:
    - copy vivos_in into an internal mask;
    - clear atq_v/prot_v/morto_valido;
    - jogador_atual = 0;
    - go to AVALIA.
  - AVALIA 1:
    - If jogador_atual is dead: go to PROXIMO.
    - Otherwise: pulse limpa_escolha and go to MOSTRA.
    - A dead player costs exactly 2 cycles (AVALIA + PROXIMO).
  - MOSTRA 2: mostra_classe = 1. On passa, go to ACAO.
  - ACAO 3: mostra_classe = 0. Actions by class of jogador_atual:
    - lobo: waits for escolha_valida with escolha < N_JOGADORES, escolha alive and escolha != jogador_atual. Invalid choices are ignored. The first wolf to act sets atacado/atq_v; later wolves do not overwrite it. After the choice, go to PROXIMO. passa is ignored.
    - medico: same validity rules, except self-protection is allowed. Sets protegido/prot_v, then goes to PROXIMO.
    - aldeao (and vidente without the option): go to PROXIMO on passa.
  - PROXIMO 4:
    - If jogador_atual == N_JOGADORES-1: go to RESOLVE.
    - Else increment jogador_atual and go to AVALIA.
  - RESOLVE 5:
    - If atq_v && !(prot_v && protegido == atacado): morto = atacado, morto_valido = 1, and vivos_out = mask with bit atacado cleared.
    - Otherwise: vivos_out = mask and morto_valido = 0.
    - Go to FIM.
  - FIM 6: fim_noite = 1 for exactly one cycle, then OCIOSO.
- Output persistence: atacado, protegido, morto, morto_valido and vivos_out hold until the next iniciar.
- Simultaneous events:
  - passa and escolha_valida in the same ACAO cycle: the choice wins for lobo/medico; passa alone advances an aldeao.
  - iniciar while ocupado: ignored.
- No wolf alive: atq_v stays 0, so nobody dies.

Optional Feature:
- Macro VIDENTE_EN.
- Defined:
  - Class 3 (vidente) in ACAO waits for a valid choice (alive, not self), then exposes the chosen player's class on an extra output revelacao[1:0], with revelacao_valida = 1.
  - Both are held until the next passa, which moves to PROXIMO.
  - Both reset to 0.
- Undefined: revelacao ports do not exist, and vidente behaves exactly as aldeao.

Decomposition:
- Package pkg_lobinho holds:
  - the class encoding constants (CLASSE_ALDEAO=0, CLASSE_LOBO=1, CLASSE_MEDICO=2, CLASSE_VIDENTE=3);
  - the state enumeration with its db_estado values;
  - the default for N_JOGADORES.
- Sub-module: none required. The target-validity check (range, alive, not-self) is natural as a small combinational sub-module valida_alvo, reused by lobo, medico and vidente.

Test Plan:
- Classes {lobo, medico, aldeao, aldeao, aldeao}, all alive. Lobo picks 3, medico picks 4 -> morto=3, morto_valido=1, vivos_out=5'b10111, one fim_noite pulse.
- Same setup, medico picks 3 -> morto_valido=0, vivos_out=5'b11111.
- vivos_in=5'b11011 (player 2 dead) -> jogador_atual skips 2; no mostra_classe for 2; AVALIA+PROXIMO for player 2 last 2 cycles total.
- Lobo selects itself (0), then dead player 2, then 7 -> all ignored and state stays ACAO; a subsequent pick of 1 is accepted with atacado=1.
- Reset driven low during ACAO of player 1 -> next edge gives state OCIOSO, ocupado=0, vivos_out=all ones, no fim_noite.
- With VIDENTE_EN, player 4 vidente picks 0 (lobo) -> revelacao=1 and revelacao_valida=1 until passa.
